// File: rtl/uart_cfg_sequencer_pkg.sv
// Shared definitions for the UART link-configuration sequencer.
//   uart_config_s   : {data_width, parity_mode, stop_bits}, 2 bits each
//   cfg_id_e        : packet identifier carried in the low two bits of a packet
//   cfg_seq_state_e : sequencer FSM states
//   CFG_DEFAULT     : link settings in force out of reset (8N1)
//   ACKN_PKT/SYN_PKT: control bytes seen on the RX path
//   assemble_packet : builds {4'b0, option, id}
//   select_option   : picks the option field that belongs to a packet id
package uart_cfg_sequencer_pkg;

    typedef struct packed {
        logic [1:0] data_width;
        logic [1:0] parity_mode;
        logic [1:0] stop_bits;
    } uart_config_s;

    typedef enum logic [1:0] {
        ID_DATA_WIDTH = 2'd0,
        ID_PARITY     = 2'd1,
        ID_STOP_BITS  = 2'd2,
        ID_END_CFG    = 2'd3
    } cfg_id_e;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_ACK,
        DONE,
        ERROR
    } cfg_seq_state_e;

    localparam uart_config_s CFG_DEFAULT = '{data_width: 2'b11, parity_mode: 2'b00, stop_bits: 2'b00};

    localparam logic [7:0] ACKN_PKT = 8'hFF;
    localparam logic [7:0] SYN_PKT  = 8'h16;

    function automatic logic [7:0] assemble_packet(input cfg_id_e id, input logic [1:0] option);
        return {4'b0000, option, id};
    endfunction

    // END_CFG carries no option; it always goes out with 2'b00.
    function automatic logic [1:0] select_option(input uart_config_s cfg, input cfg_id_e id);
        logic [1:0] opt;
        case (id)
            ID_DATA_WIDTH: opt = cfg.data_width;
            ID_PARITY:     opt = cfg.parity_mode;
            ID_STOP_BITS:  opt = cfg.stop_bits;
            default:       opt = 2'b00;
        endcase
        return opt;
    endfunction

endpackage

// File: rtl/uart_cfg_sequencer_timer.sv
// cfg_timeout_timer: ACK wait timer for the configuration sequencer.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : restart counting from zero (packet accepted by TX)
//   enable   : count while waiting for the acknowledge
//   expire   : high while enabled and the count sits at TIMEOUT_CYCLES-1
// The count saturates at TIMEOUT_CYCLES-1; the sequencer always leaves the
// wait state on expiry and clears the timer on the next accept, so it never wraps.
module cfg_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign expire = enable && (count == LAST);

endmodule

// File: rtl/uart_cfg_sequencer.sv
// uart_cfg_sequencer: negotiates a new UART link configuration with the
// remote host. A request sends DATA_WIDTH, PARITY, STOP_BITS and END_CFG
// packets, each waiting for ACKN_PKT with timeout-driven resends. The new
// settings appear on cfg_applied_o only once END_CFG is acknowledged.
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   cfg_req_i      : start request, sampled only when idle
//   cfg_i          : configuration to negotiate
//   busy_o         : negotiation in progress
//   cfg_done_o     : one-cycle pulse, all packets acknowledged
//   cfg_error_o    : one-cycle pulse, retries exhausted
//   cfg_applied_o  : configuration currently in force
//   tx_data_o/tx_valid_o/tx_ready_i : packet byte stream to the TX path
//   rx_data_i/rx_valid_i            : byte strobe from the RX path
module uart_cfg_sequencer
    import uart_cfg_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int MAX_RETRY      = 3
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cfg_req_i,
    input  uart_config_s cfg_i,
    output logic         busy_o,
    output logic         cfg_done_o,
    output logic         cfg_error_o,
    output uart_config_s cfg_applied_o,
    output logic [7:0]   tx_data_o,
    output logic         tx_valid_o,
    input  logic         tx_ready_i,
    input  logic [7:0]   rx_data_i,
    input  logic         rx_valid_i
);

    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

    cfg_seq_state_e     state;
    cfg_id_e            idx;
    cfg_id_e            next_idx;
    logic [1:0]         idx_inc;
    logic [RETRY_W-1:0] retry;
    uart_config_s       shadow;
    logic [7:0]         next_packet;

    logic tx_accept;
    logic ack_seen;
    logic timer_expire;

    // tx_valid_o is always high in SEND, so ready alone marks the handshake.
    assign tx_accept = (state == SEND) && tx_valid_o && tx_ready_i;

    // ACKs outside WAIT_ACK are stale or early and must not advance anything.
    assign ack_seen = (state == WAIT_ACK) && rx_valid_i && (rx_data_i == ACKN_PKT);

    always_comb begin
        idx_inc     = idx + 2'd1;
        next_idx    = cfg_id_e'(idx_inc);
        next_packet = assemble_packet(next_idx, select_option(shadow, next_idx));
    end

    cfg_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk_i),
        .rst    (rst_i),
        .clear  (tx_accept),
        .enable (state == WAIT_ACK),
        .expire (timer_expire)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= IDLE;
            idx           <= ID_DATA_WIDTH;
            retry         <= '0;
            shadow        <= CFG_DEFAULT;
            busy_o        <= 1'b0;
            cfg_done_o    <= 1'b0;
            cfg_error_o   <= 1'b0;
            cfg_applied_o <= CFG_DEFAULT;
            tx_data_o     <= 8'h00;
            tx_valid_o    <= 1'b0;
        end else begin
            cfg_done_o  <= 1'b0;
            cfg_error_o <= 1'b0;
            case (state)
                IDLE: begin
                    busy_o <= 1'b0;
                    if (cfg_req_i) begin
                        shadow     <= cfg_i;
                        idx        <= ID_DATA_WIDTH;
                        retry      <= '0;
                        busy_o     <= 1'b1;
                        tx_valid_o <= 1'b1;
                        tx_data_o  <= assemble_packet(ID_DATA_WIDTH, cfg_i.data_width);
                        state      <= SEND;
                    end
                end
                SEND: begin
                    if (tx_ready_i) begin
                        tx_valid_o <= 1'b0;
                        state      <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    // The ACK branch is tested first so an ACK on the expiry cycle wins.
                    if (ack_seen) begin
                        if (idx == ID_END_CFG) begin
                            state <= DONE;
                        end else begin
                            idx        <= next_idx;
                            retry      <= '0;
                            tx_valid_o <= 1'b1;
                            tx_data_o  <= next_packet;
                            state      <= SEND;
                        end
                    end else if (timer_expire) begin
                        if (retry == RETRY_LIMIT) begin
                            state <= ERROR;
                        end else begin
                            // Resend the same packet; tx_data_o still holds it.
                            retry      <= retry + 1'b1;
                            tx_valid_o <= 1'b1;
                            state      <= SEND;
                        end
                    end
                end
                DONE: begin
                    cfg_applied_o <= shadow;
                    cfg_done_o    <= 1'b1;
                    state         <= IDLE;
                end
                ERROR: begin
                    cfg_error_o <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cfg_sequencer.sv
`timescale 1ns/1ps
module tb_uart_cfg_sequencer;
    import uart_cfg_sequencer_pkg::*;

    localparam int T  = 40;
    localparam int MR = 3;
    localparam int EVT_LIMIT = 4 * (MR + 1) * (T + 6) + 200;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_req;
    logic [5:0] cfg;
    logic       busy, cfg_done, cfg_error;
    logic [5:0] applied;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;

    uart_cfg_sequencer #(.TIMEOUT_CYCLES(T), .MAX_RETRY(MR)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .cfg_req_i     (cfg_req),
        .cfg_i         (cfg),
        .busy_o        (busy),
        .cfg_done_o    (cfg_done),
        .cfg_error_o   (cfg_error),
        .cfg_applied_o (applied),
        .tx_data_o     (tx_data),
        .tx_valid_o    (tx_valid),
        .tx_ready_i    (tx_ready),
        .rx_data_i     (rx_data),
        .rx_valid_i    (rx_valid)
    );

    always #5 clk = ~clk;

    typedef struct { bit is_done; logic [5:0] cfg; } evt_t;
    typedef struct { int ack_at; bit noise; } resp_t;

    logic [7:0] exp_tx_q[$];
    int         exp_gap_q[$];
    evt_t       exp_evt_q[$];
    resp_t      plan_q[$];

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int evt_cnt = 0;
    int accept_cnt = 0;
    int stale_req = 0;
    bit hold_off = 1'b0;
    bit rand_ready = 1'b0;
    logic [5:0] model_applied = 6'b110000;

    always @(posedge clk) cycle++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s actual=%0h required=none", name, act);
    endtask

    function automatic logic [7:0] option_of(input logic [5:0] c, input int id);
        if (id == 0) return {6'b0, c[5:4]};
        if (id == 1) return {6'b0, c[3:2]};
        if (id == 2) return {6'b0, c[1:0]};
        return 8'h00;
    endfunction

    // Reference model: packet byte = option*4 + id; each failed attempt is
    // resent T cycles later; after MR resends the negotiation aborts.
    task automatic plan_neg(input logic [5:0] c, input int fails[4], input int ack_at[4], input bit noise);
        int b, k, nf;
        resp_t r;
        evt_t e;
        for (int id = 0; id < 4; id++) begin
            b  = option_of(c, id) * 4 + id;
            nf = (fails[id] > MR) ? MR + 1 : fails[id];
            for (int a = 0; a < nf; a++) begin
                exp_tx_q.push_back(8'(b));
                r.ack_at = 0; r.noise = noise;
                plan_q.push_back(r);
                exp_gap_q.push_back((fails[id] > MR && a == nf - 1) ? T + 2 : T + 1);
            end
            if (fails[id] > MR) begin
                e.is_done = 1'b0; e.cfg = c;
                exp_evt_q.push_back(e);
                return;
            end
            k = (ack_at[id] > 0) ? ack_at[id] : int'($urandom_range(1, T));
            exp_tx_q.push_back(8'(b));
            r.ack_at = k; r.noise = noise;
            plan_q.push_back(r);
            exp_gap_q.push_back((id == 3) ? k + 2 : k + 1);
        end
        e.is_done = 1'b1; e.cfg = c;
        exp_evt_q.push_back(e);
    endtask

    task automatic issue_req(input logic [5:0] c);
        @(posedge clk); #1;
        cfg = c;
        cfg_req = 1'b1;
        @(posedge clk); #1;
        cfg_req = 1'b0;
        check("busy_rise", busy, 1);
    endtask

    task automatic wait_evt(input int target);
        int n = 0;
        while (evt_cnt < target && n < EVT_LIMIT) begin
            @(posedge clk);
            n++;
        end
        if (evt_cnt < target) fail_now("evt_timeout", evt_cnt);
        repeat (3) @(posedge clk);
        #1;
        check("busy_idle", busy, 0);
    endtask

    task automatic negotiate(input logic [5:0] c, input int fails[4], input int ack_at[4], input bit noise);
        int target;
        target = evt_cnt + 1;
        plan_neg(c, fails, ack_at, noise);
        issue_req(c);
        wait_evt(target);
    endtask

    function automatic logic [7:0] noise_byte(input int c);
        if (c == 1) return SYN_PKT;
        if (c == 2) return 8'hA5;
        return 8'($urandom_range(0, 254));
    endfunction

    // TX ready driver
    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            tx_ready = hold_off ? 1'b0 : (rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
        end
    end

    // Remote host: answers each accepted packet according to plan_q
    initial begin
        resp_t r;
        int len;
        int stale_done = 0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst && tx_valid && tx_ready) begin
                if (plan_q.size() > 0) r = plan_q.pop_front();
                else begin r.ack_at = 0; r.noise = 1'b0; end
                len = (r.ack_at > 0) ? r.ack_at : T;
                @(posedge clk);
                for (int c = 1; c <= len; c++) begin
                    #1;
                    if (c == len && r.ack_at > 0) begin
                        rx_valid = 1'b1; rx_data = ACKN_PKT;
                    end else if (r.noise && (c <= 2 || $urandom_range(0, 3) == 0)) begin
                        rx_valid = 1'b1; rx_data = noise_byte(c);
                    end else begin
                        rx_valid = 1'b0;
                    end
                    @(posedge clk);
                end
                #1 rx_valid = 1'b0;
            end else if (stale_req != stale_done) begin
                stale_done = stale_req;
                rx_valid = 1'b1; rx_data = ACKN_PKT;
                @(posedge clk); #1;
                rx_valid = 1'b0;
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        bit pend = 1'b0;
        int last_acc = 0;
        bit prev_valid = 1'b0, prev_ready = 1'b0, prev_pulse = 1'b0;
        logic [7:0] prev_data = 8'h00;
        evt_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 1'b0; prev_valid = 1'b0; prev_pulse = 1'b0;
                model_applied = CFG_DEFAULT;
                continue;
            end
            if (prev_valid && !prev_ready) begin
                check("tx_valid_hold", tx_valid, 1);
                check("tx_data_hold", tx_data, prev_data);
            end
            if (tx_valid && !prev_valid && pend) begin
                if (exp_gap_q.size() > 0) check("resend_gap", cycle - last_acc, exp_gap_q.pop_front());
                else fail_now("gap_unexpected", cycle - last_acc);
                pend = 1'b0;
            end
            if (tx_valid && tx_ready) begin
                if (exp_tx_q.size() > 0) check("tx_byte", tx_data, exp_tx_q.pop_front());
                else fail_now("tx_unexpected", tx_data);
                pend = 1'b1;
                last_acc = cycle;
                accept_cnt++;
            end
            if (prev_pulse) begin
                check("busy_after_pulse", busy, 0);
                check("pulse_width", cfg_done | cfg_error, 0);
            end else if (cfg_done || cfg_error) begin
                if (pend) begin
                    if (exp_gap_q.size() > 0) check("pulse_gap", cycle - last_acc, exp_gap_q.pop_front());
                    else fail_now("gap_unexpected", cycle - last_acc);
                end
                pend = 1'b0;
                if (exp_evt_q.size() > 0) begin
                    e = exp_evt_q.pop_front();
                    check("evt_done", cfg_done, e.is_done);
                    check("evt_error", cfg_error, !e.is_done);
                    if (e.is_done) model_applied = e.cfg;
                end else begin
                    fail_now("evt_unexpected", {cfg_done, cfg_error});
                end
                check("busy_in_pulse", busy, 1);
                evt_cnt++;
            end
            check("applied", applied, model_applied);
            prev_valid = tx_valid;
            prev_ready = tx_ready;
            prev_data  = tx_data;
            prev_pulse = cfg_done | cfg_error;
        end
    end

    initial begin
        int base, n;
        logic [5:0] c;
        int f[4];
        rst = 1'b1;
        cfg_req = 1'b0;
        cfg = 6'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", cfg_done, 0);
        check("rst_error", cfg_error, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_applied", applied, CFG_DEFAULT);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // happy path
        negotiate(6'b10_01_01, '{0, 0, 0, 0}, '{2, 2, 2, 2}, 1'b0);
        check("happy_applied", applied, 6'b10_01_01);

        // single timeout on PARITY
        negotiate(6'($urandom), '{0, 1, 0, 0}, '{2, 2, 2, 2}, 1'b0);

        // abort: never acknowledged
        negotiate(6'b01_10_10, '{MR + 1, 0, 0, 0}, '{0, 0, 0, 0}, 1'b0);

        // noise during wait, ACK exactly on the timeout cycle
        negotiate(6'b00_11_10, '{0, 0, 0, 0}, '{3, T, 3, T}, 1'b1);

        // backpressure, stale ACKs, request while busy
        hold_off = 1'b1;
        repeat (2) @(posedge clk);
        stale_req++;
        repeat (3) @(posedge clk);
        c = 6'b11_10_01;
        base = accept_cnt;
        n = evt_cnt + 1;
        plan_neg(c, '{0, 0, 0, 0}, '{0, 0, 0, 0}, 1'b1);
        issue_req(c);
        repeat (3) @(posedge clk);
        stale_req++;
        repeat (3) @(posedge clk); #1;
        cfg = 6'b00_00_11;
        cfg_req = 1'b1;
        @(posedge clk); #1;
        cfg_req = 1'b0;
        repeat (12) @(posedge clk); #1;
        check("bp_no_accept", accept_cnt, base);
        check("bp_valid", tx_valid, 1);
        check("bp_data", tx_data, 8'h0C);
        hold_off = 1'b0;
        wait_evt(n);

        // randomized negotiations
        rand_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            for (int j = 0; j < 4; j++) begin
                n = $urandom_range(0, 11);
                f[j] = (n < 8) ? 0 : (n < 10) ? 1 : (n < 11) ? 2 : MR + 1;
            end
            negotiate(6'($urandom), f, '{0, 0, 0, 0}, 1'($urandom_range(0, 1)));
        end
        rand_ready = 1'b0;

        // reset while waiting for the STOP_BITS acknowledge
        negotiate(6'b10_01_01, '{0, 0, 0, 0}, '{1, 1, 1, 1}, 1'b0);
        c = 6'b01_11_00;
        for (int id = 0; id < 3; id++) begin
            resp_t r;
            exp_tx_q.push_back(8'(option_of(c, id) * 4 + id));
            r.ack_at = (id < 2) ? 3 : 0;
            r.noise = 1'b0;
            plan_q.push_back(r);
            if (id < 2) exp_gap_q.push_back(4);
        end
        base = accept_cnt;
        issue_req(c);
        n = 0;
        while (accept_cnt < base + 3 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (accept_cnt < base + 3) fail_now("rst_setup_timeout", accept_cnt - base);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_tx_valid", tx_valid, 0);
        check("mid_rst_tx_data", tx_data, 8'h00);
        check("mid_rst_done", cfg_done, 0);
        check("mid_rst_error", cfg_error, 0);
        check("mid_rst_applied", applied, CFG_DEFAULT);
        repeat (2) @(posedge clk);
        exp_tx_q.delete();
        exp_gap_q.delete();
        exp_evt_q.delete();
        #1 rst = 1'b0;
        repeat (T + 5) @(posedge clk);
        plan_q.delete();
        #1;
        check("post_rst_busy", busy, 0);
        check("post_rst_applied", applied, CFG_DEFAULT);
        negotiate(6'b01_00_01, '{0, 0, 0, 0}, '{2, 2, 2, 2}, 1'b0);
        check("post_rst_negotiation", applied, 6'b01_00_01);

        check("exp_tx_drained", exp_tx_q.size(), 0);
        check("exp_evt_drained", exp_evt_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
